// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
//
// Holds the fetch PC and selects the next PC each cycle. The sources, in
// priority order, are: trap, execute-stage redirect, stall, predicted
// return, predicted call, and sequential. A circular return-address stack
// (RAS) supplies the targets for predicted returns.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   trap_valid_i   trap/exception redirect request; trap_pc_i is the handler
//   br_redirect_i  execute-stage redirect; br_target_i is the address
//   stall_i        hold the PC (fetch back-pressure)
//   pred_call_i    predecode says the instruction at pc_o is a call
//   pred_ret_i     predecode says the instruction at pc_o is a return
//   pred_target_i  call target from predecode
//   pc_o           current fetch PC
//   pc_valid_o     pc_o is valid for fetch
//   ras_cnt_o      number of valid RAS entries
//   ras_err_o      one-cycle pulse on RAS overflow or underflow
module pc_gen #(
  parameter int unsigned XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int unsigned IALIGN          = 4,
  parameter int unsigned RAS_DEPTH       = 4,
  parameter int unsigned LEGACY_REDIRECT = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           trap_valid_i,
  input  logic [XLEN-1:0]                trap_pc_i,
  input  logic                           br_redirect_i,
  input  logic [XLEN-1:0]                br_target_i,
  input  logic                           stall_i,
  input  logic                           pred_call_i,
  input  logic                           pred_ret_i,
  input  logic [XLEN-1:0]                pred_target_i,
  output logic [XLEN-1:0]                pc_o,
  output logic                           pc_valid_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt_o,
  output logic                           ras_err_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH+1);
  localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);
  localparam logic [CW-1:0]   FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_q, top_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] ras_wdata;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ras_top_val;
  logic [PW-1:0]   top_inc;
  logic [PW-1:0]   top_dec;
  logic            ras_empty;

  assign seq_pc      = pc_q + STEP;
  assign ras_top_val = ras_q[top_q];
  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  assign top_inc     = top_q + 1'b1;
  assign top_dec     = top_q - 1'b1;
  assign ras_empty   = (cnt_q == '0);

  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    err_d     = 1'b0;
    ras_we    = 1'b0;
    ras_waddr = top_q;
    ras_wdata = seq_pc;

    if (trap_valid_i) begin
      pc_d  = trap_pc_i;
      cnt_d = '0;
      top_d = '0;
    end else if (br_redirect_i) begin
      pc_d = (LEGACY_REDIRECT != 0) ? (br_target_i + STEP) : br_target_i;
    end else if (!valid_q || stall_i) begin
      // Hold: predecode hints are not qualified until the PC is valid.
      pc_d = pc_q;
    end else if (pred_ret_i && pred_call_i) begin
      // Co-routine swap: jump to the top entry and replace it in place.
      if (!ras_empty) begin
        pc_d   = ras_top_val;
        ras_we = 1'b1;
      end else begin
        pc_d      = pred_target_i;
        top_d     = top_inc;
        cnt_d     = CW'(1);
        ras_we    = 1'b1;
        ras_waddr = top_inc;
      end
    end else if (pred_ret_i) begin
      if (!ras_empty) begin
        pc_d  = ras_top_val;
        top_d = top_dec;
        cnt_d = cnt_q - 1'b1;
      end else begin
        pc_d  = seq_pc;
        err_d = 1'b1;
      end
    end else if (pred_call_i) begin
      pc_d      = pred_target_i;
      top_d     = top_inc;
      ras_we    = 1'b1;
      ras_waddr = top_inc;
      // When full, the push lands on the oldest entry; count saturates.
      if (cnt_q == FULL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      err_q   <= err_d;
    end
  end

  // Entry contents carry no meaning after reset, so storage is not reset.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_waddr] <= ras_wdata;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign ras_cnt_o  = cnt_q;
  assign ras_err_o  = err_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic        br_redirect_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        stall_i = 1'b0;
  logic        pred_call_i = 1'b0;
  logic        pred_ret_i = 1'b0;
  logic [31:0] pred_target_i = '0;

  logic [31:0] pc_o, pc_l;
  logic        pc_valid_o, pc_valid_l;
  logic [2:0]  ras_cnt_o, ras_cnt_l;
  logic        ras_err_o, ras_err_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(4), .RAS_DEPTH(4),
           .LEGACY_REDIRECT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .br_redirect_i(br_redirect_i), .br_target_i(br_target_i),
    .stall_i(stall_i), .pred_call_i(pred_call_i), .pred_ret_i(pred_ret_i),
    .pred_target_i(pred_target_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .ras_cnt_o(ras_cnt_o), .ras_err_o(ras_err_o)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(4), .RAS_DEPTH(4),
           .LEGACY_REDIRECT(1)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .br_redirect_i(br_redirect_i), .br_target_i(br_target_i),
    .stall_i(stall_i), .pred_call_i(pred_call_i), .pred_ret_i(pred_ret_i),
    .pred_target_i(pred_target_i),
    .pc_o(pc_l), .pc_valid_o(pc_valid_l),
    .ras_cnt_o(ras_cnt_l), .ras_err_o(ras_err_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trap_valid_i  = 1'b0;
    br_redirect_i = 1'b0;
    stall_i       = 1'b0;
    pred_call_i   = 1'b0;
    pred_ret_i    = 1'b0;
  endtask

  // Position the PC with a trap, which also empties the RAS.
  task automatic go_to(input logic [31:0] addr);
    idle();
    trap_valid_i = 1'b1;
    trap_pc_i    = addr;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h100; exp_seq[1] = 32'h100;
    exp_seq[2] = 32'h104; exp_seq[3] = 32'h108;
    rst_n = 1'b0;
    idle();
    step();
    n_checks++;
    if (pc_o !== 32'h100 || pc_valid_o !== 1'b0 || ras_cnt_o !== 3'd0 || ras_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h valid=%b cnt=%0d err=%b, want pc=100 valid=0 cnt=0 err=0",
               pc_o, pc_valid_o, ras_cnt_o, ras_err_o);
    end
    rst_n = 1'b1;
    n_checks++;
    if (pc_o !== exp_seq[0] || pc_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: pc=%h valid=%b, want pc=%h valid=0", pc_o, pc_valid_o, exp_seq[0]);
    end
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++;
      if (pc_o !== exp_seq[i] || pc_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: pc=%h valid=%b, want pc=%h valid=1", i, pc_o, pc_valid_o, exp_seq[i]);
      end
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc_o !== 32'h100 || pc_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h valid=%b, want pc=100 valid=0", pc_o, pc_valid_o);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_priority();
    go_to(32'h400);
    pred_call_i   = 1'b1;
    pred_target_i = 32'h600;
    step();
    idle();
    n_checks++;
    if (ras_cnt_o !== 3'd1) begin
      n_fail++;
      $display("FAIL prio_setup_cnt: cnt=%0d, want 1", ras_cnt_o);
    end
    trap_valid_i  = 1'b1; trap_pc_i = 32'h80;
    br_redirect_i = 1'b1; br_target_i = 32'h200;
    stall_i       = 1'b1;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h80 || ras_cnt_o !== 3'd0) begin
      n_fail++;
      $display("FAIL trap_priority: pc=%h cnt=%0d, want pc=80 cnt=0", pc_o, ras_cnt_o);
    end
    br_redirect_i = 1'b1; br_target_i = 32'h200;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h200) begin
      n_fail++;
      $display("FAIL redirect: pc=%h, want 200", pc_o);
    end
    n_checks++;
    if (pc_l !== 32'h204) begin
      n_fail++;
      $display("FAIL legacy_redirect: pc=%h, want 204", pc_l);
    end
  endtask

  task automatic test_call_ret();
    go_to(32'h1000);
    pred_call_i = 1'b1; pred_target_i = 32'h2000;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h2000 || ras_cnt_o !== 3'd1) begin
      n_fail++;
      $display("FAIL call: pc=%h cnt=%0d, want pc=2000 cnt=1", pc_o, ras_cnt_o);
    end
    pred_ret_i = 1'b1;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h1004 || ras_cnt_o !== 3'd0) begin
      n_fail++;
      $display("FAIL return: pc=%h cnt=%0d, want pc=1004 cnt=0", pc_o, ras_cnt_o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
    go_to(32'h10);
    for (int i = 1; i <= 5; i++) begin
      pred_call_i   = 1'b1;
      pred_target_i = 32'h10 * (i + 1);
      step();
      n_checks++;
      if (pc_o !== 32'h10 * (i + 1) || ras_cnt_o !== ((i > 4) ? 3'd4 : 3'(i)) ||
          ras_err_o !== (i == 5)) begin
        n_fail++;
        $display("FAIL nested_call[%0d]: pc=%h cnt=%0d err=%b, want pc=%h cnt=%0d err=%0d",
                 i, pc_o, ras_cnt_o, ras_err_o, 32'h10 * (i + 1), (i > 4) ? 4 : i, (i == 5));
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      pred_ret_i = 1'b1;
      step();
      n_checks++;
      if (pc_o !== exp_ret[i] || ras_cnt_o !== 3'(3 - i) || ras_err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL lifo_return[%0d]: pc=%h cnt=%0d err=%b, want pc=%h cnt=%0d err=0",
                 i, pc_o, ras_cnt_o, ras_err_o, exp_ret[i], 3 - i);
      end
    end
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h28 || ras_cnt_o !== 3'd0 || ras_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: pc=%h cnt=%0d err=%b, want pc=28 cnt=0 err=1", pc_o, ras_cnt_o, ras_err_o);
    end
    step();
    n_checks++;
    if (pc_o !== 32'h2c || ras_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: pc=%h err=%b, want pc=2c err=0", pc_o, ras_err_o);
    end
  endtask

  task automatic test_swap();
    go_to(32'h3000);
    pred_call_i = 1'b1; pred_target_i = 32'h500;
    step();
    pred_ret_i = 1'b1; pred_target_i = 32'h9999;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h3004 || ras_cnt_o !== 3'd1) begin
      n_fail++;
      $display("FAIL swap_nonempty: pc=%h cnt=%0d, want pc=3004 cnt=1", pc_o, ras_cnt_o);
    end
    pred_ret_i = 1'b1;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h504 || ras_cnt_o !== 3'd0) begin
      n_fail++;
      $display("FAIL swap_top_rewrite: pc=%h cnt=%0d, want pc=504 cnt=0", pc_o, ras_cnt_o);
    end
    pred_call_i = 1'b1; pred_ret_i = 1'b1; pred_target_i = 32'h700;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h700 || ras_cnt_o !== 3'd1 || ras_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_empty: pc=%h cnt=%0d err=%b, want pc=700 cnt=1 err=0", pc_o, ras_cnt_o, ras_err_o);
    end
    pred_ret_i = 1'b1;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h508) begin
      n_fail++;
      $display("FAIL swap_empty_push: pc=%h, want 508", pc_o);
    end
  endtask

  task automatic test_stall_wrap();
    go_to(32'h900);
    stall_i = 1'b1; pred_call_i = 1'b1; pred_target_i = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc_o !== 32'h900 || ras_cnt_o !== 3'd0) begin
        n_fail++;
        $display("FAIL stall[%0d]: pc=%h cnt=%0d, want pc=900 cnt=0", i, pc_o, ras_cnt_o);
      end
    end
    br_redirect_i = 1'b1; br_target_i = 32'h950;
    step();
    idle();
    n_checks++;
    if (pc_o !== 32'h950) begin
      n_fail++;
      $display("FAIL redirect_in_stall: pc=%h, want 950", pc_o);
    end
    br_redirect_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    step();
    idle();
    step();
    n_checks++;
    if (pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h, want 0", pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_call_ret();
    test_overflow();
    test_swap();
    test_stall_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
